dlx_fetch_buffer: RTL



---
 rtl/dlx_fetch_pkg.sv | 15 +
 rtl/dlx_fetch_fifo.sv | 77 +++++++
 rtl/dlx_fetch_buffer.sv | 85 ++++++++
 3 files changed

// File: rtl/dlx_fetch_pkg.sv
// Shared widths, reset PC and the buffered entry layout for the DLX instruction prefetch stage.
package dlx_fetch_pkg;

    localparam int DLX_DATA_WIDTH      = 32;
    localparam int DLX_INST_ADDR_WIDTH = 20;
    localparam int DLX_DEPTH           = 4;

    localparam logic [DLX_INST_ADDR_WIDTH-1:0] DLX_RESET_PC = '0;

    typedef struct packed {
        logic [DLX_INST_ADDR_WIDTH-1:0] pc;
        logic [DLX_DATA_WIDTH-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/dlx_fetch_fifo.sv
// First-word fall-through FIFO holding {pc, instr} entries; flush empties it in one cycle.
module dlx_fetch_fifo #(
    parameter int WIDTH = 52,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_last;
    logic [WIDTH-1:0] w_head;
    logic             w_wr;

    assign w_wr = i_push & ~i_flush;

    // Once drained, the outputs keep showing the most recent head rather than stale storage.
    assign w_head  = (r_count != '0) ? r_mem[r_rd_ptr] : r_last;
    assign o_head  = w_head;
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_wr && (r_wr_ptr == PW'(gi))) begin
                    r_mem[gi] <= i_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            r_last <= w_head;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                assert (!(i_push && !i_pop && (r_count == CW'(DEPTH))));
                assert (!(i_pop && (r_count == '0)));
                if (i_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (i_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (i_push && !i_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!i_push && i_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dlx_fetch_buffer.sv
// Instruction prefetch: sequential ROM reads with credit-based issue, PC tagging and redirect flush.
module dlx_fetch_buffer
    import dlx_fetch_pkg::*;
#(
    parameter int DATA_WIDTH      = DLX_DATA_WIDTH,
    parameter int INST_ADDR_WIDTH = DLX_INST_ADDR_WIDTH,
    parameter int DEPTH           = DLX_DEPTH,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = INST_ADDR_WIDTH'(DLX_RESET_PC)
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          rom_rd_en,
    output logic [INST_ADDR_WIDTH-1:0]    rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic                          fetch_valid,
    output logic [DATA_WIDTH-1:0]         fetch_instr,
    output logic [INST_ADDR_WIDTH-1:0]    fetch_pc,
    input  logic                          fetch_ready,
    input  logic                          redirect,
    input  logic [INST_ADDR_WIDTH-1:0]    redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]    fill_level
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = INST_ADDR_WIDTH + DATA_WIDTH;

    logic [INST_ADDR_WIDTH-1:0] r_next_pc;
    logic [INST_ADDR_WIDTH-1:0] r_rsp_pc;
    logic                       r_rsp_pending;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit;
    logic [EW-1:0] w_head;
    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;

    assign w_pop  = w_valid & fetch_ready & ~redirect;
    assign w_push = r_rsp_pending & ~redirect;

    // Entries held plus the read in flight, less the one leaving now, must leave room for one more.
    assign w_credit = {1'b0, w_count} + (CW+1)'(r_rsp_pending) - (CW+1)'(w_pop);
    assign w_issue  = ~rst & ~redirect & (w_credit < (CW+1)'(DEPTH));

    assign rom_rd_en   = w_issue;
    assign rom_addr    = r_next_pc;
    assign fetch_valid = w_valid;
    assign fetch_pc    = w_head[EW-1 -: INST_ADDR_WIDTH];
    assign fetch_instr = w_head[DATA_WIDTH-1:0];
    assign fill_level  = w_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_next_pc     <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_rsp_pending <= 1'b0;
        end else if (redirect) begin
            r_next_pc     <= redirect_pc;
            r_rsp_pending <= 1'b0;
        end else begin
            r_rsp_pending <= w_issue;
            if (w_issue) begin
                r_next_pc <= r_next_pc + 1'b1;
                r_rsp_pc  <= r_next_pc;
            end
        end
    end

    dlx_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (rst),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_data  ({r_rsp_pc, rom_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

endmodule
